// File: rtl/pipelined_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit widths_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// One carry-chain slice of the pipelined adder: an SW-bit ripple adder of
// full_adder cells, also exposing the carry into its MSB for overflow.
import pipelined_adder_pkg::*;

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);
  logic [SW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SW; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[SW];
  assign c_msb_in = c[SW-1];
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split over STAGES register stages with valid/ready flow control.
// Define PIPELINED_ADDER_SUB_EN to add the 'sub' port (a - b as a + ~b + 1).
import pipelined_adder_pkg::*;

module pipelined_adder #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int SW = slice_width(WIDTH, STAGES);

  if (!widths_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 1 and divisible by STAGES");
  end

  logic             adv;
  logic             vld_q   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] b_eff;
  logic             c0;

`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c0    = cin;
`endif

  logic [SW-1:0] sl_a  [STAGES];
  logic [SW-1:0] sl_b  [STAGES];
  logic [SW-1:0] sl_s  [STAGES];
  logic          sl_ci [STAGES];
  logic          sl_co [STAGES];
  logic          sl_cm [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign sl_a[0]  = a[SW-1:0];
      assign sl_b[0]  = b_eff[SW-1:0];
      assign sl_ci[0] = c0;
    end else begin : g_rest
      // Later stages see operands and carry as registered by the stage before.
      assign sl_a[k]  = a_q[k-1][k*SW +: SW];
      assign sl_b[k]  = b_q[k-1][k*SW +: SW];
      assign sl_ci[k] = carry_q[k-1];
    end

    adder_slice #(.SW(SW)) u_slice (
      .a        (sl_a[k]),
      .b        (sl_b[k]),
      .cin      (sl_ci[k]),
      .sum      (sl_s[k]),
      .cout     (sl_co[k]),
      .c_msb_in (sl_cm[k])
    );
  end

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]   <= 1'b0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
    end else if (adv) begin
      vld_q[0]   <= in_valid;
      sum_q[0]   <= WIDTH'(sl_s[0]);
      carry_q[0] <= sl_co[0];
      a_q[0]     <= a;
      b_q[0]     <= b_eff;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k]               <= vld_q[k-1];
        sum_q[k]               <= sum_q[k-1];
        sum_q[k][k*SW +: SW]   <= sl_s[k];
        carry_q[k]             <= sl_co[k];
        a_q[k]                 <= a_q[k-1];
        b_q[k]                 <= b_q[k-1];
      end
      ovf_q <= sl_co[STAGES-1] ^ sl_cm[STAGES-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=8, STAGES=4; the subtract
// vectors run only when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
`ifdef PIPELINED_ADDER_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [9:0]  exp_q[$];
  int          acc_q[$];
  bit          chk_lat = 1'b1;
  bit          seen_front = 1'b0;
  int          run_len = 0;
  int          max_run = 0;
  int          n_pop = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: {overflow, cout, sum} from integer arithmetic and operand signs.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {8'd0, c};
    v = (x[7] == y[7]) && (t[7] != x[7]);
    return {v, t[8], t[7:0]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare every presented result against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        check("result", int'({overflow, cout, sum}), int'(exp_q[0]));
        if (!seen_front) begin
          seen_front = 1'b1;
          if (chk_lat) check("latency", cyc - acc_q[0], S);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          seen_front = 1'b0;
          n_pop++;
        end else begin
          check("in_ready_stall", int'(in_ready), 0);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic s, input logic [9:0] e);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
    sub = s;
`endif
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [7:0] x, y;
    logic       c;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);

    // Directed vectors with hand-computed {overflow, cout, sum}.
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 10'h100);
    idle();
    drain();
    issue(8'h7F, 8'h00, 1'b1, 1'b0, 10'h280);
    issue(8'h80, 8'h80, 1'b0, 1'b0, 10'h300);
    issue(8'h12, 8'h34, 1'b1, 1'b0, 10'h047);
    issue(8'hF0, 8'h0F, 1'b1, 1'b0, 10'h100);
    issue(8'h40, 8'h40, 1'b0, 1'b0, 10'h280);
    idle();
    drain();

    // Streaming: 16 back-to-back random ops.
    repeat (3) @(posedge clk);
    max_run = 0;
    p0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      issue(x, y, c, 1'b0, model(x, y, c));
    end
    idle();
    drain();
    check("stream_run", max_run, 16);
    check("stream_count", n_pop - p0, 16);

    // Backpressure: out_ready low for 5 cycles mid-stream.
    chk_lat = 1'b0;
    p0 = n_pop;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          x = 8'($urandom);
          y = 8'($urandom);
          c = 1'($urandom);
          issue(x, y, c, 1'b0, model(x, y, c));
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_pop - p0, 12);
    chk_lat = 1'b1;

    // Reset with 3 ops in flight: none of them may come out.
    issue(8'h01, 8'h02, 1'b0, 1'b0, 10'h003);
    issue(8'h03, 8'h04, 1'b0, 1'b0, 10'h007);
    issue(8'h05, 8'h06, 1'b0, 1'b0, 10'h00B);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    seen_front = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_valid", int'(out_valid), 0);
    end

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction; cin is ignored, so drive it to 1 to prove that.
    issue(8'h05, 8'h07, 1'b1, 1'b1, 10'h0FE);
    issue(8'h80, 8'h01, 1'b1, 1'b1, 10'h37F);
    issue(8'h07, 8'h05, 1'b0, 1'b1, 10'h102);
    idle();
    drain();
`endif

    // Back to plain add after everything else.
    issue(8'hAA, 8'h55, 1'b1, 1'b0, 10'h100);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
